// File: rtl/streebog_core_g.sv
// Streebog compression g_N(h,m): drives an external LPS core through 25 calls
// (K1, then 12x {X round, key schedule}) and folds the result with h and m.

module streebog_rom_c_table (
  input  logic         clk,
  input  logic [3:0]   addr,
  output logic [511:0] data
);
  always_ff @(posedge clk) begin
    case (addr)
      4'd0:  data <= 512'hb1085bda1ecadae9_ebcb2f81c0657c1f_2f6a76432e45d016_714eb88d7585c4fc_4b7ce09192676901_a2422a08a460d315_05767436cc744d23_dd806559f2a64507;
      4'd1:  data <= 512'h6fa3b58aa99d2f1a_4fe39d460f70b5d7_f3feea720a232b98_61d55e0f16b50131_9ab5176b12d69958_5cb561c2db0aa7ca_55dda21bd7cbcd56_e679047021b19bb7;
      4'd2:  data <= 512'hf574dcac2bce2fc7_0a39fc286a3d8435_06f15e5f529c1f8b_f2ea7514b1297b7b_d3e20fe490359eb1_c1c93a376062db09_c2b6f443867adb31_991e96f50aba0ab2;
      4'd3:  data <= 512'hef1fdfb3e81566d2_f948e1a05d71e4dd_488e857e335c3c7d_9d721cad685e353f_a9d72c82ed03d675_d8b71333935203be_3453eaa193e837f1_220cbebc84e3d12e;
      4'd4:  data <= 512'h4bea6bacad474799_9a3f410c6ca92363_7f151c1f1686104a_359e35d7800fffbd_bfcd1747253af5a3_dfff00b723271a16_7a56a27ea9ea63f5_601758fd7c6cfe57;
      4'd5:  data <= 512'hae4faeae1d3ad3d9_6fa4c33b7a3039c0_2d66c4f95142a46c_187f9ab49af08ec6_cffaa6b71c9ab7b4_0af21f66c2bec6b6_bf71c57236904f35_fa68407a46647d6e;
      4'd6:  data <= 512'hf4c70e16eeaac5ec_51ac86febf240954_399ec6c7e6bf87c9_d3473e33197a93c9_0992abc52d822c37_06476983284a0504_3517454ca23c4af3_8886564d3a14d493;
      4'd7:  data <= 512'h9b1f5b424d93c9a7_03e7aa020c6e4141_4eb7f8719c36de1e_89b4443b4ddbc49a_f4892bcb929b0690_69d18d2bd1a5c42f_36acc2355951a8d9_a47f0dd4bf02e71e;
      4'd8:  data <= 512'h378f5a541631229b_944c9ad8ec165fde_3a7d3a1b25894224_3cd955b7e00d0984_800a440bdbb2ceb1_7b2b8a9aa6079c54_0e38dc92cb1f2a60_7261445183235adb;
      4'd9:  data <= 512'habbedea680056f52_382ae548b2e4f3f3_8941e71cff8a78db_1fffe18a1b336103_9fe76702af69334b_7a1e6c303b7652f4_3698fad1153bb6c3_74b4c7fb98459ced;
      4'd10: data <= 512'h7bcd9ed0efc889fb_3002c6cd635afe94_d8fa6bbbebab0761_2001802114846679_8a1d71efea48b9ca_efbacd1d7d476e98_dea2594ac06fd85d_6bcaa4cd81f32d1b;
      4'd11: data <= 512'h378ee767f11631ba_d21380b00449b17a_cda43c32bcdf1d77_f82012d430219f9b_5d80ef9d1891cc86_e71da4aa88e12852_faf417d5d9b21b99_48bc924af11bd720;
      default: data <= '0;
    endcase
  end
endmodule

module streebog_core_g (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  output logic         rdy,
  output logic         last,
  input  logic [511:0] h,
  input  logic [511:0] n,
  input  logic [511:0] m,
  output logic [511:0] dout,
  output logic         lps_ena,
  input  logic         lps_rdy,
  output logic [511:0] lps_din,
  input  logic [511:0] lps_dout
);
  typedef enum logic [2:0] {IDLE, ISSUE_K, WAIT_K, ISSUE_X, WAIT_X, ISSUE_C, WAIT_C} state_t;

  state_t       state, state_nx;
  logic [3:0]   round;
  logic [511:0] h_r, n_r, m_r, st_r, key_r, c_data;

  streebog_rom_c_table u_rom (.clk(clk), .addr(round), .data(c_data));

  assign rdy  = (state == IDLE);
  assign last = (state == WAIT_C) && (round == 4'd11) && lps_rdy;

  // ISSUE states hold off until lps_rdy so a run orphaned by reset drains first
  always_comb begin
    state_nx = state;
    lps_ena  = 1'b0;
    lps_din  = '0;
    case (state)
      IDLE:    if (ena) state_nx = ISSUE_K;
      ISSUE_K: begin
        lps_din = h_r ^ n_r;
        lps_ena = lps_rdy;
        if (lps_rdy) state_nx = WAIT_K;
      end
      WAIT_K: begin
        lps_din = h_r ^ n_r;
        if (lps_rdy) state_nx = ISSUE_X;
      end
      ISSUE_X: begin
        lps_din = st_r ^ key_r;
        lps_ena = lps_rdy;
        if (lps_rdy) state_nx = WAIT_X;
      end
      WAIT_X: begin
        lps_din = st_r ^ key_r;
        if (lps_rdy) state_nx = ISSUE_C;
      end
      ISSUE_C: begin
        lps_din = key_r ^ c_data;
        lps_ena = lps_rdy;
        if (lps_rdy) state_nx = WAIT_C;
      end
      WAIT_C: begin
        lps_din = key_r ^ c_data;
        if (lps_rdy) state_nx = (round == 4'd11) ? IDLE : ISSUE_X;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      round <= '0;
      dout  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && ena) round <= '0;
      if (state == WAIT_C && lps_rdy) begin
        if (round == 4'd11) dout  <= st_r ^ lps_dout ^ h_r ^ m_r;
        else                round <= round + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (ena) begin
        h_r  <= h;
        n_r  <= n;
        m_r  <= m;
        st_r <= m;
      end
      WAIT_K: if (lps_rdy) key_r <= lps_dout;
      WAIT_X: if (lps_rdy) st_r  <= lps_dout;
      WAIT_C: if (lps_rdy && round != 4'd11) key_r <= lps_dout;
      default: ;
    endcase
  end
endmodule

// File: doc/streebog_core_g.md
Name: streebog_core_g

Overview:
- Streebog compression function g_N(h, m) = E(LPS(h^N), m) ^ h ^ m.
- Sequences all 25 LPS transformations through one external streebog_core_lps instance, acting as initiator on its ena/rdy/last handshake.
- Generates round keys K1..K13 from the 12 iteration constants C1..C12, held in an internal streebog_rom_c_table (registered read, 1-cycle latency, 4-bit address 0..11, 512-bit data).
- Sits between the message-block controller (which supplies h, N, m) and the LPS core.

Parameters:
- none: rounds fixed at 12; LPS pipeline depth is set on the external LPS instance.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  start flag, sampled only while rdy=1
- rdy  out  1  idle/done; dout valid while high after a run
- last  out  1  high for exactly one cycle, the cycle before rdy rises
- h  in  512  chaining value, sampled on ena&rdy
- n  in  512  block counter N, sampled on ena&rdy
- m  in  512  message block, sampled on ena&rdy
- dout  out  512  new chaining value
- lps_ena  out  1  start pulse to LPS core
- lps_rdy  in  1  LPS core ready
- lps_din  out  512  LPS operand, held stable for the whole LPS run
- lps_dout  in  512  LPS result, valid while lps_rdy=1 after a run

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, rdy=1, last=0, lps_ena=0, dout=0, round=0. Reset mid-run aborts the run; internal registers are don't-care.
- The LPS core has no reset. After reset, IDLE must not issue until lps_rdy=1, so an orphaned LPS run drains first.
- Start (ena&rdy at cycle s): register h, n, m; state_reg<=m; rdy<=0; round<=0; go to ISSUE_K. ena is ignored while rdy=0.
- ISSUE_* states: lps_ena=1 for exactly one cycle, entered only when lps_rdy=1. Next state is WAIT_*.
- WAIT_* states: hold lps_din. Complete on the first cycle with lps_rdy=1 and capture lps_dout in that cycle.
- lps_din per state:
  - ISSUE_K/WAIT_K: h^n.
  - ISSUE_X/WAIT_X: state_reg^key.
  - ISSUE_C/WAIT_C: key^C[round].
- Transitions:
  - WAIT_K done: key<=result, then ISSUE_X.
  - WAIT_X done: state_reg<=result, then ISSUE_C.
  - WAIT_C done, round<11: key<=result, round<=round+1, then ISSUE_X.
  - WAIT_C done, round==11: dout<=state_reg^result^h^m, rdy<=1, then IDLE.
- C ROM: address=round, driven continuously. Data is stable at least one cycle before ISSUE_C.
- Call count: exactly 1+12+12=25 lps_ena pulses per run; never two pulses without an intervening lps_rdy=0.
- Timing: T = cycles from lps_ena to lps_rdy high again (65 for the 8x8 LPS). Each call costs T+1 cycles.
- Latency: rdy rises at cycle s+25(T+1)+1, i.e. s+1651 for T=65.
- last: high in the capture cycle of the 25th call (combinational from state WAIT_C, round==11, lps_rdy).
- dout: holds its value until the next completed run. It is not altered by starting a new run until that run completes.
- Back-to-back: ena held high at the rdy-rise cycle starts the next run in that cycle; the new inputs are sampled then.
- All XORs are full 512-bit; there is no arithmetic carry.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, ena=0 -> rdy=1, last=0, lps_ena=0, dout=0; no lps_ena for 100 cycles.
- Known answer: h=0, n=0, m=padded 63-byte GOST R 34.11-2012 example M1, with the 8x8 LPS core attached -> dout equals the software-model g_0 value; rdy rises exactly 1651 cycles after ena; exactly 25 lps_ena pulses.
- Handshake monitor: random h/n/m, 20 runs -> lps_din is constant from each lps_ena until lps_rdy=1; lps_ena is only asserted when lps_rdy=1; last is one cycle and immediately precedes rdy rise.
- LPS depth sweep: LPS core configured 2x2 (T=5) and 8x64 (T=513) -> dout identical to the model; latencies 151 and 12851 cycles.
- Mid-run reset: rst_n=0 at cycle s+300 for 1 cycle, ena on the next cycle -> the first new lps_ena waits for lps_rdy=1; the run completes with the correct dout for the new inputs.
- Ignored ena and back-to-back: pulse ena during busy -> no effect. Hold ena high across completion -> the second run starts at the rdy-rise cycle; the first dout is stable until the second completes.
